fib_sequencer: RTL

Initiator-side controller for the staged Fibonacci engine. On a start pulse it fetches two seed words from data memory, drives the engine's stage/currentnum/address/number inputs through its two load stages, waits for the engine's ready, captures the result and optionally writes it back to memory. It sits between the CPU's memory port and the Fibonacci engine, and the engine is instantiated beside it at top level.

---
 rtl/fib_pkg.sv | 26 ++
 rtl/fib_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// fib_pkg : shared state encoding, engine stage codes and address offsets
// Rev 1.0 : initial release
// ============================================================================
package fib_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_LD1  = 3'd2,
      S_LD2  = 3'd3,
      S_RUN  = 3'd4,
      S_WB   = 3'd5,
      S_DONE = 3'd6
   } fib_state_t;

   localparam logic [1:0] STAGE_RUN   = 2'd0;
   localparam logic [1:0] STAGE_LOAD1 = 2'd1;
   localparam logic [1:0] STAGE_LOAD2 = 2'd2;

   localparam int unsigned SEED1_OFS  = 1;
   localparam int unsigned RESULT_OFS = 2;

endpackage
`default_nettype wire

// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
// fib_sequencer : fetches two seeds, loads the Fibonacci engine, captures its
//                 result; FIB_SEQ_WRITEBACK_EN adds a result write to base+2
// Rev 1.0 : initial release
// ============================================================================
module fib_sequencer
   import fib_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] start_index,
   input  logic [AW-1:0] target_index,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_wr,
   output logic [DW-1:0] mem_wdata,
   output logic [1:0]    stage,
   output logic [DW-1:0] currentnum,
   output logic [AW-1:0] address,
   output logic [AW-1:0] number,
   input  logic          eng_ready,
   input  logic [DW-1:0] eng_out,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] result
);

   fib_state_t    state_q,  state_d;
   logic [AW-1:0] base_q,   base_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [AW-1:0] num_q,    num_d;
   logic [DW-1:0] result_q, result_d;
   logic          err_q,    err_d;
   logic          guard_q,  guard_d;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         addr_q   <= '0;
         num_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         guard_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         addr_q   <= addr_d;
         num_q    <= num_d;
         result_q <= result_d;
         err_q    <= err_d;
         guard_q  <= guard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      addr_d     = addr_q;
      num_d      = num_q;
      result_d   = result_q;
      err_d      = err_q;
      guard_d    = 1'b0;
      mem_addr   = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      // Default parks the engine: repeated num1 loads keep its counter still.
      stage      = STAGE_LOAD1;
      currentnum = '0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               addr_d  = start_index;
               num_d   = target_index;
               err_d   = (start_index > target_index);
               state_d = err_d ? S_DONE : S_RD0;
            end
         end
         S_RD0: begin
            mem_rd   = 1'b1;
            mem_addr = base_q;
            state_d  = S_LD1;
         end
         S_LD1: begin
            currentnum = mem_rdata;
            mem_rd     = 1'b1;
            mem_addr   = base_q + AW'(SEED1_OFS);
            state_d    = S_LD2;
         end
         S_LD2: begin
            stage      = STAGE_LOAD2;
            currentnum = mem_rdata;
            guard_d    = 1'b1;
            state_d    = S_RUN;
         end
         S_RUN: begin
            stage = STAGE_RUN;
            // eng_ready may still be high from the previous job on the first RUN cycle.
            if (!guard_q && eng_ready) begin
               result_d = eng_out;
`ifdef FIB_SEQ_WRITEBACK_EN
               state_d  = S_WB;
`else
               state_d  = S_DONE;
`endif
            end
         end
`ifdef FIB_SEQ_WRITEBACK_EN
         S_WB: begin
            mem_wr    = 1'b1;
            mem_addr  = base_q + AW'(RESULT_OFS);
            mem_wdata = result_q;
            state_d   = S_DONE;
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign err     = err_q;
   assign result  = result_q;
   assign address = addr_q;
   assign number  = num_q;

endmodule
`default_nettype wire
